// File: rtl/sq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sq_pkg
// Description : Shared store-queue definitions. Holds the funct3 size
//               encodings and the byte-lane mask generator used by both
//               the store path and the load lookup path.
// Revision    : 1.0 - initial release
// ============================================================================
package sq_pkg;

  // funct3 encodings of the store/load access size
  localparam logic [2:0] SQ_F3_BYTE = 3'b000;
  localparam logic [2:0] SQ_F3_HALF = 3'b001;
  localparam logic [2:0] SQ_F3_WORD = 3'b010;

  // Access size as carried in funct3[1:0]
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } sq_size_e;

  // Byte enables inside the 32-bit word for an access of the given size
  // at the given byte offset. Halfwords ignore offset[0].
  // Size 2'b11 is treated as a full word.
  function automatic logic [3:0] sq_byte_mask(input logic [1:0] size,
                                              input logic [1:0] offset);
    logic [3:0] mask;
    mask = 4'b1111;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = 4'b0011 << {offset[1], 1'b0};
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : store_queue_if
// Description : Bundle of all store-queue signals except clock and reset.
//               in_*  : driven by the core side (master)
//               out_* : driven by the store queue (slave)
//               Covers the alloc, commit, flush, load-lookup and cache-drain
//               channels.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_queue_if #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 4
);
  logic                 in_alloc;
  logic [XLEN-1:0]      in_addr;
  logic [XLEN-1:0]      in_data;
  logic [2:0]           in_funct3;
  logic [ROB_IDX_W-1:0] in_rob_idx;
  logic                 out_stall;
  logic                 in_complete;
  logic [ROB_IDX_W-1:0] in_complete_idx;
  logic                 in_flush;
  logic                 in_ld_valid;
  logic [XLEN-1:0]      in_ld_addr;
  logic [2:0]           in_ld_funct3;
  logic                 out_ld_hit;
  logic [XLEN-1:0]      out_ld_data;
  logic                 out_ld_conflict;
  logic                 out_cache_valid;
  logic [XLEN-1:0]      out_cache_addr;
  logic [XLEN-1:0]      out_cache_data;
  logic [3:0]           out_cache_mask;
  logic                 in_cache_ready;

  modport master (
    output in_alloc, in_addr, in_data, in_funct3, in_rob_idx,
    output in_complete, in_complete_idx, in_flush,
    output in_ld_valid, in_ld_addr, in_ld_funct3, in_cache_ready,
    input  out_stall, out_ld_hit, out_ld_data, out_ld_conflict,
    input  out_cache_valid, out_cache_addr, out_cache_data, out_cache_mask
  );

  modport slave (
    input  in_alloc, in_addr, in_data, in_funct3, in_rob_idx,
    input  in_complete, in_complete_idx, in_flush,
    input  in_ld_valid, in_ld_addr, in_ld_funct3, in_cache_ready,
    output out_stall, out_ld_hit, out_ld_data, out_ld_conflict,
    output out_cache_valid, out_cache_addr, out_cache_data, out_cache_mask
  );
endinterface
`default_nettype wire

// File: rtl/sq_bypass_match.sv
`default_nettype none
// ============================================================================
// Module      : sq_bypass_match
// Description : Youngest-match search for store-to-load forwarding.
//               Walks from tail-1 back towards head and picks the first valid
//               entry that has the same word address and shares at least one
//               byte lane with the load.
//   Ports : ent_valid/ent_addr/ent_mask - per-entry state
//           head/tail                   - queue pointers
//           ld_addr/ld_mask             - load word address and lanes
//           hit_idx                     - matching entry
//           hit                         - match covers every load lane
//           conflict                    - match covers only some load lanes
// Revision    : 1.0 - initial release
// ============================================================================
module sq_bypass_match #(
  parameter int SQ_DEPTH = 8,
  parameter int AW       = 30,
  parameter int PTR_W    = $clog2(SQ_DEPTH)
) (
  input  logic [SQ_DEPTH-1:0]         ent_valid,
  input  logic [SQ_DEPTH-1:0][AW-1:0] ent_addr,
  input  logic [SQ_DEPTH-1:0][3:0]    ent_mask,
  input  logic [PTR_W-1:0]            head,
  input  logic [PTR_W-1:0]            tail,
  input  logic [AW-1:0]               ld_addr,
  input  logic [3:0]                  ld_mask,
  output logic [PTR_W-1:0]            hit_idx,
  output logic                        hit,
  output logic                        conflict
);

  logic [PTR_W-1:0] idx;
  logic             found;
  logic             done;
  logic [3:0]       match_mask;

  always_comb begin
    idx        = '0;
    found      = 1'b0;
    done       = 1'b0;
    match_mask = '0;
    hit_idx    = '0;
    // k == SQ_DEPTH wraps back to tail itself, which is the oldest slot
    // when the queue is full.
    for (int k = 1; k <= SQ_DEPTH; k++) begin
      idx = tail - PTR_W'(k);
      if (!found && !done && ent_valid[idx] && (ent_addr[idx] == ld_addr) &&
          ((ent_mask[idx] & ld_mask) != 4'b0000)) begin
        found      = 1'b1;
        hit_idx    = idx;
        match_mask = ent_mask[idx];
      end
      if (idx == head) begin
        done = 1'b1;
      end
    end
    hit      = found && ((match_mask & ld_mask) == ld_mask);
    conflict = found && ((match_mask & ld_mask) != ld_mask);
  end

endmodule
`default_nettype wire

// File: rtl/store_queue.sv
`default_nettype none
// ============================================================================
// Module      : store_queue
// Description : Circular store queue with in-order commit, cache drain from
//               the head and combinational store-to-load forwarding.
//   Ports : clk   - rising-edge clock
//           reset - synchronous active-high reset
//           sq    - store_queue_if.slave (alloc, commit, flush, load
//                   lookup, cache drain)
// Revision    : 1.0 - initial release
// ============================================================================
module store_queue
  import sq_pkg::*;
#(
  parameter int SQ_DEPTH  = 8,
  parameter int ROB_IDX_W = 4,
  parameter int XLEN      = 32
) (
  input  logic          clk,
  input  logic          reset,
  store_queue_if.slave  sq
);

  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AW    = XLEN - 2;

  logic [SQ_DEPTH-1:0]                valid_q, valid_d, comm_q, comm_d;
  logic [SQ_DEPTH-1:0][AW-1:0]        addr_q, addr_d;
  logic [SQ_DEPTH-1:0][XLEN-1:0]      data_q, data_d;
  logic [SQ_DEPTH-1:0][3:0]           mask_q, mask_d;
  logic [SQ_DEPTH-1:0][ROB_IDX_W-1:0] rob_q, rob_d;
  logic [PTR_W-1:0]                   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]                   count_q, count_d;

  logic [SQ_DEPTH-1:0] comm_next;
  logic [CNT_W-1:0]    ncomm;
  logic                full, alloc_ok, head_ready, pop;
  logic [3:0]          ld_mask;
  logic [PTR_W-1:0]    hit_idx;
  logic                hit, conflict;
  logic                unused_funct3_msb;

  // funct3[2] only distinguishes signed/unsigned loads; lanes ignore it
  assign unused_funct3_msb = sq.in_funct3[2] ^ sq.in_ld_funct3[2];

  assign full       = (count_q == CNT_W'(SQ_DEPTH));
  assign alloc_ok   = sq.in_alloc && !full;
  assign head_ready = valid_q[head_q] && comm_q[head_q];
  assign pop        = head_ready && sq.in_cache_ready;

  // Commit lands before a same-cycle flush, so the flush boundary is
  // computed from the post-commit bits.
  always_comb begin
    comm_next = comm_q;
    ncomm     = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (sq.in_complete && valid_q[i] && (rob_q[i] == sq.in_complete_idx)) begin
        comm_next[i] = 1'b1;
      end
      if (valid_q[i] && comm_next[i]) begin
        ncomm = ncomm + CNT_W'(1);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    comm_d  = comm_next;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (sq.in_flush) begin
      // Committed entries are contiguous from head, so the survivors are
      // exactly head .. head+ncomm-1.
      valid_d = valid_q & comm_next;
      comm_d  = valid_q & comm_next;
      tail_d  = head_q + ncomm[PTR_W-1:0];
      count_d = ncomm - CNT_W'(pop);
    end else begin
      if (alloc_ok) begin
        valid_d[tail_q] = 1'b1;
        comm_d[tail_q]  = 1'b0;
        addr_d[tail_q]  = sq.in_addr[XLEN-1:2];
        data_d[tail_q]  = sq.in_data << {sq.in_addr[1:0], 3'b000};
        mask_d[tail_q]  = sq_byte_mask(sq.in_funct3[1:0], sq.in_addr[1:0]);
        rob_d[tail_q]   = sq.in_rob_idx;
        tail_d          = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(alloc_ok) - CNT_W'(pop);
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      comm_d[head_q]  = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      comm_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      comm_q  <= comm_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    mask_q <= mask_d;
    rob_q  <= rob_d;
  end

  assign ld_mask = sq_byte_mask(sq.in_ld_funct3[1:0], sq.in_ld_addr[1:0]);

  sq_bypass_match #(
    .SQ_DEPTH (SQ_DEPTH),
    .AW       (AW),
    .PTR_W    (PTR_W)
  ) u_match (
    .ent_valid (valid_q),
    .ent_addr  (addr_q),
    .ent_mask  (mask_q),
    .head      (head_q),
    .tail      (tail_q),
    .ld_addr   (sq.in_ld_addr[XLEN-1:2]),
    .ld_mask   (ld_mask),
    .hit_idx   (hit_idx),
    .hit       (hit),
    .conflict  (conflict)
  );

  // Outputs are forced quiet while reset is asserted
  assign sq.out_stall       = full && !reset;
  assign sq.out_cache_valid = head_ready && !reset;
  assign sq.out_cache_addr  = sq.out_cache_valid ? {addr_q[head_q], 2'b00} : '0;
  assign sq.out_cache_data  = sq.out_cache_valid ? data_q[head_q] : '0;
  assign sq.out_cache_mask  = sq.out_cache_valid ? mask_q[head_q] : 4'b0000;
  assign sq.out_ld_hit      = sq.in_ld_valid && hit && !reset;
  assign sq.out_ld_conflict = sq.in_ld_valid && conflict && !reset;
  assign sq.out_ld_data     = sq.out_ld_hit ? data_q[hit_idx] : '0;

endmodule
`default_nettype wire
